// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-to-device transmitter.
//   ps2_state_e  : transmitter FSM states
//   ERR_*        : err_code values reported by ps2_host_tx
//   CMD_*        : common keyboard command bytes
//   odd_parity() : PS/2 parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_IDLE = 3'd5,
        ERROR     = 3'd6
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NACK    = 2'd2;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // PS/2 frames use odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer, level filter and falling-edge detector for
// the PS2_CLK pin.
//   clk, rst : system clock, synchronous active-high reset
//   pin      : raw asynchronous pin level
//   level    : filtered level; follows the synchronized pin only after
//              FILTER_LEN consecutive samples disagree with it
//   fall     : one-cycle pulse when level goes 1 -> 0
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] run_cnt;

    // The idle bus is high, so reset everything to the released level to
    // avoid a spurious fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            // stage p0/p1: metastability synchronizer
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            // filter stage: count consecutive disagreeing samples
            fall <= 1'b0;
            if (sync_p1 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync_p1;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte to the
// keyboard over open-drain PS2_CLK/PS2_DATA (oe=1 pulls the line low).
//   clk, rst        : system clock, synchronous active-high reset
//   tx_start        : one-cycle request, accepted only when idle
//   tx_data[7:0]    : byte to send, latched on accept
//   tx_busy         : high from accept until done or error
//   tx_done         : one-cycle pulse, byte sent and ACKed, bus idle again
//   tx_err          : one-cycle pulse on failure
//   err_code[1:0]   : 0 none, 1 timeout, 2 NACK; held until next accept
//   rx_inhibit      : copy of tx_busy, tells the receive decoder to ignore the bus
//   ps2_clk_i/data_i: raw pin levels
//   ps2_clk_oe/data_oe : 1 = pull the line low
// Build option: define PS2_TX_RETRY_EN to retry a failed transfer once with
// the same byte before reporting an error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_INHIBIT   = INHIBIT;
    localparam logic [2:0] S_REQ       = REQ;
    localparam logic [2:0] S_SEND      = SEND;
    localparam logic [2:0] S_WAIT_ACK  = WAIT_ACK;
    localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;
    localparam logic [2:0] S_ERROR     = ERROR;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [2:0]    state;
    logic [7:0]    shreg;
    logic          parity;
    logic [3:0]    n_fall;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] wdog;
    logic [FW-1:0] idle_cnt;

    logic          data_sync_p0;
    logic          data_sync_p1;
    logic          clk_level;
    logic          clk_fall;

    logic          accept;
    logic          watch_active;
    logic          idle_done;
    logic          nack_hit;
    logic          timeout_hit;
    logic          fail;
    logic [1:0]    fail_code;
    logic          retry_now;

    assign rx_inhibit = tx_busy;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // Data path: latched byte and DATA synchronizer carry no reset; they are
    // only consulted in states that are entered through an accept.
    always_ff @(posedge clk) begin
        // stage p0/p1: PS2_DATA synchronizer (no filtering; only sampled on a fall
        // or while waiting for the bus to go idle)
        data_sync_p0 <= ps2_data_i;
        data_sync_p1 <= data_sync_p0;
        if (accept) begin
            shreg  <= tx_data;
            parity <= odd_parity(tx_data);
        end
    end

    always_comb begin
        // A start pulse landing on the tx_done cycle is dropped.
        accept       = (state == S_IDLE) && tx_start && !tx_done;
        watch_active = (state == S_SEND) || (state == S_WAIT_ACK) || (state == S_WAIT_IDLE);
        idle_done    = (state == S_WAIT_IDLE) && clk_level && data_sync_p1 &&
                       (idle_cnt == FW'(FILTER_LEN - 1));
        nack_hit     = (state == S_WAIT_ACK) && clk_fall && data_sync_p1;
        // A fall that arrives on the last watchdog cycle still counts as progress.
        timeout_hit  = watch_active && !clk_fall && !idle_done &&
                       (wdog == TW'(TIMEOUT_CYCLES - 1));
        fail         = nack_hit || timeout_hit;
        fail_code    = nack_hit ? ERR_NACK : ERR_TIMEOUT;
    end

`ifdef PS2_TX_RETRY_EN
    logic retry_used;

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_used <= 1'b0;
        end else if (accept) begin
            retry_used <= 1'b0;
        end else if (fail) begin
            retry_used <= 1'b1;
        end
    end

    assign retry_now = fail && !retry_used;
`else
    assign retry_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= ERR_NONE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            n_fall      <= '0;
            inh_cnt     <= '0;
            wdog        <= '0;
            idle_cnt    <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            if (watch_active) begin
                wdog <= clk_fall ? '0 : wdog + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state       <= S_INHIBIT;
                        tx_busy     <= 1'b1;
                        err_code    <= ERR_NONE;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        inh_cnt     <= '0;
                    end
                end

                // Clock is released on the same edge the start bit is driven,
                // so clk_oe is high for exactly INHIBIT_CYCLES cycles.
                S_INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        state       <= S_REQ;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    n_fall <= '0;
                    wdog   <= '0;
                    state  <= S_SEND;
                end

                // n_fall holds the number of falls already seen, so the bit
                // driven after this fall is indexed by its old value.
                S_SEND: begin
                    if (clk_fall) begin
                        n_fall <= n_fall + 1'b1;
                        if (n_fall < 4'd8) begin
                            ps2_data_oe <= ~shreg[n_fall[2:0]];
                        end else if (n_fall == 4'd8) begin
                            ps2_data_oe <= ~parity;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_WAIT_ACK;
                        end
                    end
                end

                S_WAIT_ACK: begin
                    if (clk_fall && !data_sync_p1) begin
                        state    <= S_WAIT_IDLE;
                        idle_cnt <= '0;
                    end
                end

                S_WAIT_IDLE: begin
                    if (idle_done) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end else if (clk_level && data_sync_p1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end

                S_ERROR: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Failure handling overrides whatever the state decided this cycle.
            if (retry_now) begin
                state       <= S_INHIBIT;
                ps2_clk_oe  <= 1'b1;
                ps2_data_oe <= 1'b0;
                inh_cnt     <= '0;
            end else if (fail) begin
                state       <= S_ERROR;
                tx_err      <= 1'b1;
                err_code    <= fail_code;
                tx_busy     <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// keyboard model on the open-drain bus. Timing parameters are scaled down so
// complete frames fit in a short run.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TMO  = 1500;
    localparam int FLT  = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       rx_inhibit;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk;
    logic       dev_data;
    logic       pin_clk;
    logic       pin_data;

    // Wired-AND bus: either side may pull a line low.
    assign pin_clk  = dev_clk & ~ps2_clk_oe;
    assign pin_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_i   (pin_clk),
        .ps2_data_i  (pin_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int         passed = 0;
    int         total = 0;
    int         oe_cycles = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [2:0] err_lines = '0;
    logic [1:0] err_code_snap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // One clock step; observes outputs on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (ps2_clk_oe) oe_cycles++;
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            err_lines     = {ps2_clk_oe, ps2_data_oe, tx_busy};
            err_code_snap = err_code;
        end
    endtask

    // Bits the keyboard should read on rising edges 1..10:
    // [7:0] data LSB first, [8] odd parity, [9] stop.
    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b};
    endfunction

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // Returns on the first cycle the start bit is driven with the clock released.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 100; i++) begin
            tick();
            if (ps2_data_oe && !ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (tx_done || tx_err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Keyboard model: clocks nfalls bits, reading DATA on each rising edge;
    // on the 11th bit it pulls DATA low as ACK when ack is set.
    task automatic device_frame(input int nfalls, input bit ack, input bit glitch,
                                output logic [9:0] seen);
        seen = '0;
        repeat (20) tick();
        if (glitch) begin
            dev_clk = 1'b0;
            repeat (FLT - 1) tick();
            dev_clk = 1'b1;
            repeat (20) tick();
        end
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (10) tick();
            end
            dev_clk = 1'b0;
            repeat (HALF) tick();
            dev_clk = 1'b1;
            if (k <= 10) seen[k-1] = pin_data;
            repeat (HALF) tick();
        end
        dev_data = 1'b1;
    endtask

    task automatic run_ack(input logic [7:0] b, input bit glitch, input string tag);
        bit         ok;
        logic [9:0] seen;
        done_cnt = 0;
        start_tx(b);
        wait_req(ok);
        check({tag, "_req"}, 32'(ok), 32'd1);
        check({tag, "_start_bit"}, 32'(pin_data), 32'd0);
        device_frame(11, 1'b1, glitch, seen);
        check({tag, "_frame"}, 32'(seen), 32'(expected_frame(b)));
        wait_end(200, ok);
        check({tag, "_done"}, 32'(tx_done), 32'd1);
        check({tag, "_err_code"}, 32'(err_code), 32'(ERR_NONE));
        tick();
        check({tag, "_idle_after"}, 32'(tx_busy), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        bit         ok;
        logic [9:0] seen;
        logic [7:0] b;
        int         n;
        logic [7:0] bytes[$];

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (4) tick();

        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_code", 32'(err_code), 32'(ERR_NONE));
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_inhibit", 32'(rx_inhibit), 32'd0);
        rst = 1'b0;
        tick();

        // Set-LED command, with a second start pulse while busy.
        oe_cycles = 0;
        done_cnt  = 0;
        start_tx(CMD_SET_LED);
        check("ed_busy_on_accept", 32'(tx_busy), 32'd1);
        check("ed_rx_inhibit", 32'(rx_inhibit), 32'd1);
        repeat (5) tick();
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        wait_req(ok);
        check("ed_req", 32'(ok), 32'd1);
        check("ed_inhibit_len", 32'(oe_cycles), 32'(INH));
        check("ed_start_bit", 32'(pin_data), 32'd0);
        device_frame(11, 1'b1, 1'b0, seen);
        check("ed_frame", 32'(seen), 32'(expected_frame(CMD_SET_LED)));
        wait_end(200, ok);
        check("ed_done", 32'(tx_done), 32'd1);
        check("ed_err_code", 32'(err_code), 32'(ERR_NONE));
        // Start pulse on the tx_done cycle must be dropped.
        tx_data  = CMD_RESET;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("ed_done_pulse_width", 32'(tx_done), 32'd0);
        check("ed_start_on_done_dropped", 32'(tx_busy), 32'd0);
        check("ed_done_count", 32'(done_cnt), 32'd1);
        tick();
        check("ed_still_idle", 32'(tx_busy), 32'd0);

        // Directed parity corners, commands and random bytes; one frame
        // carries a short clock glitch that must not count as a fall.
        bytes = {8'h00, 8'h01, CMD_ENABLE, CMD_ECHO, CMD_RESET};
        for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < bytes.size(); i++) begin
            run_ack(bytes[i], (i == 3), $sformatf("byte%0d", i));
        end

        // NACK from the keyboard.
        b        = 8'($urandom_range(0, 255));
        err_cnt  = 0;
        done_cnt = 0;
        start_tx(b);
        wait_req(ok);
        check("nack_req", 32'(ok), 32'd1);
        device_frame(11, 1'b0, 1'b0, seen);
        check("nack_frame", 32'(seen), 32'(expected_frame(b)));
`ifdef PS2_TX_RETRY_EN
        wait_req(ok);
        check("retry_req", 32'(ok), 32'd1);
        device_frame(11, 1'b1, 1'b0, seen);
        check("retry_frame", 32'(seen), 32'(expected_frame(b)));
        wait_end(200, ok);
        check("retry_done", 32'(tx_done), 32'd1);
        check("retry_no_err", 32'(err_cnt), 32'd0);
        tick();
`else
        repeat (20) tick();
        check("nack_err_count", 32'(err_cnt), 32'd1);
        check("nack_code", 32'(err_code_snap), 32'(ERR_NACK));
        check("nack_lines_released", 32'(err_lines), 32'd0);
        check("nack_code_held", 32'(err_code), 32'(ERR_NACK));
        check("nack_no_done", 32'(done_cnt), 32'd0);
`endif

        // Keyboard never clocks: watchdog expires. Expected latency from the
        // first start-bit cycle is the REQ cycle plus TIMEOUT_CYCLES.
        err_cnt = 0;
        start_tx(CMD_ENABLE);
        wait_req(ok);
        check("tmo_req", 32'(ok), 32'd1);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 2 * (INH + TMO) + 400; i++) begin
            tick();
            n++;
            if (tx_err) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_err_seen", 32'(ok), 32'd1);
`ifndef PS2_TX_RETRY_EN
        check("tmo_latency", 32'(n), 32'(TMO + 1));
`endif
        check("tmo_code", 32'(err_code_snap), 32'(ERR_TIMEOUT));
        check("tmo_err_count", 32'(err_cnt), 32'd1);
        check("tmo_lines_released", 32'(err_lines), 32'd0);
        tick();

        // Reset after five bits, then a fresh command completes.
        start_tx(CMD_SET_LED);
        check("accept_clears_code", 32'(err_code), 32'(ERR_NONE));
        wait_req(ok);
        check("rst_req", 32'(ok), 32'd1);
        device_frame(5, 1'b1, 1'b0, seen);
        b = CMD_SET_LED;
        check("rst_partial_bits", 32'(seen[4:0]), 32'(b[4:0]));
        rst = 1'b1;
        tick();
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        run_ack(CMD_ENABLE, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
